// File: rtl/m_prog_loader.sv
// m_prog_loader
// UART program loader for the processor's 4K-word instruction memory.
// After reset it receives a 16-bit little-endian word count and then a stream
// of little-endian 32-bit words over an 8N1 serial line. Each word is written
// to consecutive word addresses starting at 0. When the image is complete the
// processor clock-enable is raised and held until the next reset.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (must be >= 4)
//   MAX_WORDS    : memory capacity in words; larger counts are saturated
// Ports
//   w_clk   in   system clock, rising edge
//   w_rst_n in   synchronous active-low reset
//   w_rxd   in   UART receive line, idle high, LSB first, asynchronous
//   w_addr  out  memory word address
//   w_we    out  memory write strobe, one cycle per word
//   w_din   out  memory write data
//   w_ce    out  processor clock-enable, high once loading is complete
//   w_busy  out  inverse of w_ce
//   w_err   out  sticky error: framing error or oversized count
module m_prog_loader #(
    parameter int CLKS_PER_BIT = 100,
    parameter int MAX_WORDS    = 4096
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_rxd,
    output logic [11:0] w_addr,
    output logic        w_we,
    output logic [31:0] w_din,
    output logic        w_ce,
    output logic        w_busy,
    output logic        w_err
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]     MAX_CNT   = 16'(MAX_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [1:0] {S_CNT0, S_CNT1, S_DATA, S_DONE} l_state_t;

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q;
    r_state_t      r_state_q, r_state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid;
    logic          frame_err;

    always_comb begin
        r_state_d  = r_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (!rx_s2_q) begin
                    clk_cnt_d = '0;
                    r_state_d = R_START;
                end
            end
            R_START: begin
                // Resample mid start bit; a high level means a glitch.
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    r_state_d = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            R_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        r_state_d = R_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            R_STOP: begin
                // Back to idle on the sample cycle so a start bit that
                // follows immediately is still caught.
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    r_state_d = R_IDLE;
                    if (rx_s2_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- loader ----------------
    l_state_t    l_state_q, l_state_d;
    logic [7:0]  cnt_lo_q, cnt_lo_d;
    logic [15:0] count_q, count_d;
    logic [11:0] addr_q, addr_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] din_q, din_d;
    logic        we_q, we_d;
    logic        ce_q, ce_d;
    logic        err_q, err_d;
    logic [15:0] full_count;

    always_comb begin
        l_state_d  = l_state_q;
        cnt_lo_d   = cnt_lo_q;
        count_d    = count_q;
        addr_d     = addr_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        din_d      = din_q;
        we_d       = 1'b0;
        ce_d       = ce_q;
        err_d      = err_q | frame_err;
        full_count = {shift_q, cnt_lo_q};
        case (l_state_q)
            S_CNT0: begin
                if (byte_valid) begin
                    cnt_lo_d  = shift_q;
                    l_state_d = S_CNT1;
                end
            end
            S_CNT1: begin
                if (byte_valid) begin
                    if (full_count == 16'd0) begin
                        ce_d      = 1'b1;
                        l_state_d = S_DONE;
                    end else if (full_count > MAX_CNT) begin
                        err_d     = 1'b1;
                        count_d   = MAX_CNT;
                        l_state_d = S_DATA;
                    end else begin
                        count_d   = full_count;
                        l_state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Cycle after a write: either advance the address or finish.
                // The address is not bumped after the last word because a
                // full-size image would wrap the 12-bit address to 0.
                if (we_q) begin
                    if ({4'd0, addr_q} == count_q - 16'd1) begin
                        ce_d      = 1'b1;
                        l_state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 12'd1;
                    end
                end
                if (byte_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = shift_q;
                        2'd1: word_d[15:8]  = shift_q;
                        2'd2: word_d[23:16] = shift_q;
                        default: begin
                            din_d = {shift_q, word_q};
                            we_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_DONE: ce_d = 1'b1;
            default: l_state_d = S_CNT0;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            r_state_q  <= R_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            l_state_q  <= S_CNT0;
            cnt_lo_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            ce_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_s1_q    <= w_rxd;
            rx_s2_q    <= rx_s1_q;
            r_state_q  <= r_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            l_state_q  <= l_state_d;
            cnt_lo_q   <= cnt_lo_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            din_q      <= din_d;
            we_q       <= we_d;
            ce_q       <= ce_d;
            err_q      <= err_d;
        end
    end

    assign w_addr = addr_q;
    assign w_we   = we_q;
    assign w_din  = din_q;
    assign w_ce   = ce_q;
    assign w_busy = ~ce_q;
    assign w_err  = err_q;

endmodule

// File: tb/tb_m_prog_loader.sv
// Directed testbench for m_prog_loader with CLKS_PER_BIT=4, MAX_WORDS=4.
// Serial bytes are driven bit by bit; outputs are checked 1 time unit after
// the rising edge at hand-computed cycles.
module tb_m_prog_loader;
    localparam int CPB = 4;
    localparam int MW  = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd   = 1'b1;
    logic [11:0] w_addr;
    logic        w_we;
    logic [31:0] w_din;
    logic        w_ce;
    logic        w_busy;
    logic        w_err;

    int checks     = 0;
    int errors     = 0;
    int we_total   = 0;
    int we_with_ce = 0;
    int base       = 0;

    m_prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MW)) dut (
        .w_clk  (clk),
        .w_rst_n(rst_n),
        .w_rxd  (rxd),
        .w_addr (w_addr),
        .w_we   (w_we),
        .w_din  (w_din),
        .w_ce   (w_ce),
        .w_busy (w_busy),
        .w_err  (w_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_we) we_total <= we_total + 1;
        if (w_we && w_ce) we_with_ce <= we_with_ce + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; returns 1 unit after the
    // 40th edge, one cycle before the receiver samples the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], 1'b1);
    endtask

    task automatic expect_write(input string tag, input logic [11:0] a, input logic [31:0] d);
        tick(1);
        check({tag, "_we"}, 32'(w_we), 32'd1);
        check({tag, "_addr"}, 32'(w_addr), 32'(a));
        check({tag, "_din"}, w_din, d);
    endtask

    task automatic reset_dut(input string tag);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check({tag, "_addr"}, 32'(w_addr), 32'd0);
        check({tag, "_we"}, 32'(w_we), 32'd0);
        check({tag, "_din"}, w_din, 32'd0);
        check({tag, "_ce"}, 32'(w_ce), 32'd0);
        check({tag, "_busy"}, 32'(w_busy), 32'd1);
        check({tag, "_err"}, 32'(w_err), 32'd0);
    endtask

    initial begin
        // ---- basic load ----
        reset_dut("rst0");
        base = we_total;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0000_0013);
        expect_write("basic_w0", 12'd0, 32'h0000_0013);
        check("basic_w0_ce", 32'(w_ce), 32'd0);
        tick(1);
        check("basic_addr_inc", 32'(w_addr), 32'd1);
        send_word(32'hDEAD_BEEF);
        expect_write("basic_w1", 12'd1, 32'hDEAD_BEEF);
        check("basic_w1_ce", 32'(w_ce), 32'd0);
        tick(1);
        check("basic_ce", 32'(w_ce), 32'd1);
        check("basic_busy", 32'(w_busy), 32'd0);
        check("basic_we_low", 32'(w_we), 32'd0);
        check("basic_addr_hold", 32'(w_addr), 32'd1);
        check("basic_err", 32'(w_err), 32'd0);
        check("basic_nwrites", 32'(we_total - base), 32'd2);

        // ---- zero count ----
        reset_dut("rst_zero");
        base = we_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("zero_ce_early", 32'(w_ce), 32'd0);
        tick(1);
        check("zero_ce", 32'(w_ce), 32'd1);
        tick(20);
        check("zero_nwrites", 32'(we_total - base), 32'd0);
        check("zero_err", 32'(w_err), 32'd0);

        // ---- framing error ----
        reset_dut("rst_frame");
        base = we_total;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b0);
        tick(1);
        check("frame_err_set", 32'(w_err), 32'd1);
        tick(8);
        send_word(32'h4433_2211);
        expect_write("frame_w0", 12'd0, 32'h4433_2211);
        tick(1);
        check("frame_ce", 32'(w_ce), 32'd1);
        check("frame_err_sticky", 32'(w_err), 32'd1);
        check("frame_nwrites", 32'(we_total - base), 32'd1);

        // ---- false start ----
        reset_dut("rst_false");
        base = we_total;
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(10);
        check("false_err", 32'(w_err), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hCAFE_F00D);
        expect_write("false_w0", 12'd0, 32'hCAFE_F00D);
        tick(1);
        check("false_ce", 32'(w_ce), 32'd1);
        check("false_err_end", 32'(w_err), 32'd0);
        check("false_nwrites", 32'(we_total - base), 32'd1);

        // ---- overflow count 0x1001 saturated to MAX_WORDS=4 ----
        reset_dut("rst_ovf");
        base = we_total;
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        tick(1);
        check("ovf_err", 32'(w_err), 32'd1);
        send_word(32'h1000_0000);
        expect_write("ovf_w0", 12'd0, 32'h1000_0000);
        send_word(32'h1111_1111);
        expect_write("ovf_w1", 12'd1, 32'h1111_1111);
        send_word(32'h2222_2222);
        expect_write("ovf_w2", 12'd2, 32'h2222_2222);
        check("ovf_ce_before", 32'(w_ce), 32'd0);
        send_word(32'h3333_3333);
        expect_write("ovf_w3", 12'd3, 32'h3333_3333);
        tick(1);
        check("ovf_ce", 32'(w_ce), 32'd1);
        check("ovf_addr_hold", 32'(w_addr), 32'd3);
        send_word(32'h5555_5555);
        tick(5);
        check("ovf_nwrites", 32'(we_total - base), 32'd4);
        check("ovf_ce_hold", 32'(w_ce), 32'd1);
        check("ovf_err_hold", 32'(w_err), 32'd1);

        // ---- reset mid-load ----
        reset_dut("rst_mid0");
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hA5A5_5A5A);
        expect_write("mid_w0", 12'd0, 32'hA5A5_5A5A);
        tick(2);
        check("mid_addr1", 32'(w_addr), 32'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        reset_dut("rst_mid1");
        base = we_total;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h1234_5678);
        expect_write("mid_w_fresh", 12'd0, 32'h1234_5678);
        tick(1);
        check("mid_ce", 32'(w_ce), 32'd1);
        check("mid_nwrites", 32'(we_total - base), 32'd1);

        check("we_while_ce", 32'(we_with_ce), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_prog_loader.md
# m_prog_loader

UART program loader that writes the other side of the instruction-memory port. After reset it receives a word count and a stream of little-endian 32-bit words over a serial line and writes them to consecutive word addresses of the processor's 4K-word memory. When the image is complete it releases the processor by raising the clock-enable that feeds m_proc14's w_ce. It sits between the board's UART RX pin, the memory write port (w_addr / w_we / w_din) and the processor enable.

## Interface
- CLKS_PER_BIT, 100: clock cycles per UART bit; must be at least 4.
- MAX_WORDS, 4096: memory capacity in words; the largest count honoured.
- w_clk  in  1  system clock; all logic on its rising edge.
- w_rst_n  in  1  reset; synchronous, active-low.
- w_rxd  in  1  UART receive line, idle high, 8N1, LSB first; asynchronous to w_clk.
- w_addr  out  12  memory word address.
- w_we  out  1  memory write strobe, one cycle per word.
- w_din  out  32  memory write data.
- w_ce  out  1  processor clock-enable; high once loading is complete.
- w_busy  out  1  equals ~w_ce.
- w_err  out  1  sticky error flag: framing error, or count above MAX_WORDS.

## Operation
- **Reset values** (w_rst_n low at a rising edge): w_addr=0, w_we=0, w_din=0, w_ce=0, w_busy=1, w_err=0, loader state=S_CNT0, receiver state=R_IDLE.
- **RX synchronizer:** w_rxd passes through a 2-flop synchronizer, reset to 1. All sampling uses the synchronized signal.
- **Receiver FSM:**
  - R_IDLE: a synchronized 0 starts a bit counter and moves to R_START.
  - R_START: after CLKS_PER_BIT/2 cycles (integer division), resample. If 0, go to R_DATA. If 1, it was a false start; return to R_IDLE with no byte and no error.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, shifting LSB first.
  - R_STOP: sample once after another CLKS_PER_BIT cycles.
    - Stop=1: pulse byte_valid for one cycle with the data byte.
    - Stop=0: no byte_valid; set w_err.
    - Either way, return to R_IDLE in the same cycle, so a start bit beginning on the next cycle is detected.
- **Loader FSM** (advances only on byte_valid):
  - S_CNT0: latch count[7:0] and go to S_CNT1.
  - S_CNT1: the full count is {byte, count[7:0]}.
    - Count of 0: go to S_DONE.
    - Count above MAX_WORDS: set w_err, saturate the count to MAX_WORDS, go to S_DATA.
    - Otherwise: go to S_DATA.
  - S_DATA: assemble bytes into a word (byte 0 → bits [7:0] ... byte 3 → bits [31:24]).
    - On the 4th byte, w_din=word and w_we=1 for exactly one cycle at the current w_addr. The byte counter clears.
    - On the cycle after the write, w_addr increments. After the last word it goes to S_DONE instead; w_addr then holds the last written address, since w_addr is 12 bits and MAX_WORDS wraps to 0 otherwise.
  - S_DONE: w_ce=1, w_busy=0, held until reset. Further serial bytes are received but ignored; they cause no writes and no w_err changes except framing errors.
- **Error behaviour:** a framing-error byte is discarded; it does not advance the loader. w_err stays set until reset.
- **Reset mid-operation:** everything returns to reset values, including a partially assembled word and w_ce. Memory contents already written are not touched.

## Timing
- byte_valid occurs on the cycle of the stop-bit sample: about 9.5×CLKS_PER_BIT cycles after the start-bit falling edge, plus the 2-cycle synchronizer.
- w_we is registered: it is high on the cycle after the byte_valid of the word's 4th byte. w_addr and w_din are stable throughout that cycle.
- w_addr increments on the cycle after w_we.
- w_ce rises on the cycle after the last w_we. For count=0, it rises on the cycle after the second count byte's byte_valid.
- w_we is never high while w_ce=1.
- Throughput is one word per 40 bit-times; there is no back-pressure.

## Test plan
Benches use CLKS_PER_BIT=4.
- **Basic load:** send count 0x0002, then words 0x00000013 and 0xDEADBEEF (bytes 13 00 00 00 EF BE AD DE).
  - Required: w_we at w_addr=0 with 0x00000013, then at w_addr=1 with 0xDEADBEEF.
  - w_ce rises one cycle after the second write; w_err=0.
- **Zero count:** send bytes 00 00.
  - Required: no w_we; w_ce=1 one cycle after the second byte.
- **Framing error:** in a 1-word load, send byte 0xAA with stop bit=0, then bytes 11 22 33 44.
  - Required: w_err=1; a single write of 0x44332211 at address 0; w_ce=1.
- **False start:** a 1-cycle low glitch on w_rxd in R_IDLE, then a normal 1-word load of 0xCAFEF00D.
  - Required: no spurious byte, w_err=0, correct write at address 0.
- **Overflow count:** count 0x1001 with MAX_WORDS=4.
  - Required: w_err=1 after the count; exactly 4 writes at addresses 0..3; then w_ce=1.
  - Extra bytes sent afterwards cause no writes.
- **Reset mid-load:** after 2 of 4 bytes of a word, pulse w_rst_n low for 1 cycle.
  - Required: all outputs return to reset values.
  - A fresh count 0x0001 plus word 0x12345678 writes 0x12345678 at address 0.
